pipe_flow_ctrl: RTL and testbench
=================================

PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, range 2..255: maximum data-memory wait cycles before abort.
REQ-002 Parameter CNT_W, default 32: width of the stall statistics counter.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1_raddr_i, id_rs2_raddr_i  in  5 each  source register addresses of the instruction in ID.
REQ-006 id_rs1_re_i, id_rs2_re_i  in  1 each  source register read enables in ID.
REQ-007 ex_reg_waddr_i  in  5  destination register address of the instruction in EX.
REQ-008 ex_reg_we_i  in  1  EX register write enable.
REQ-009 ex_mtype_i  in  1  EX instruction is a memory access.
REQ-010 ex_mem_rw_i  in  1  EX access direction: 0 = load, 1 = store.
REQ-011 ex_jump_i  in  1  EX resolved a taken branch or jump.
REQ-012 exmem_mtype_i  in  1  MEM-stage instruction is a memory access.
REQ-013 mem_ready_i  in  1  data memory completes the MEM-stage access this cycle.
REQ-014 fc_bk_pc_o, fc_bk_ifid_o, fc_bk_idex_o, fc_bk_exmem_o  out  1 each  hold the PC or the named pipeline register.
REQ-015 fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o  out  1 each  clear the named pipeline register to a bubble.
REQ-016 mem_err_o  out  1  one-cycle pulse on memory-wait timeout.
REQ-017 stall_cnt_o  out  CNT_W  count of cycles in which fc_bk_pc_o was asserted.

Function
REQ-018 Pipeline registers give hold priority over flush; the block SHALL never assert a bk and a flush for the same register in one cycle.
REQ-019 State machine states: RUN and MEM_WAIT; wait counter wait_cnt is 8 bits wide.
REQ-020 mem_stall = exmem_mtype_i & !mem_ready_i.
REQ-021 In RUN with mem_stall=1, same-cycle (combinational) outputs: bk_pc, bk_ifid, bk_idex, bk_exmem=1; flush_memwb=1. Next state MEM_WAIT; wait_cnt=1.
REQ-022 In MEM_WAIT with mem_stall=1 and wait_cnt<MEM_TIMEOUT: same outputs as REQ-021; wait_cnt increments by 1.
REQ-023 In MEM_WAIT with mem_ready_i=1: no memory stall that cycle; next state RUN; wait_cnt=0.
REQ-024 In MEM_WAIT with mem_stall=1 and wait_cnt==MEM_TIMEOUT (timeout): bk_pc, bk_ifid, bk_idex=1; bk_exmem=0; flush_exmem=1; flush_memwb=1. Next state RUN; wait_cnt=0; mem_err_o=1 on the following cycle only.
REQ-025 Load-use hazard, LU = ex_mtype_i & !ex_mem_rw_i & ex_reg_we_i & (ex_reg_waddr_i!=0) & ((id_rs1_re_i & rs1==waddr) | (id_rs2_re_i & rs2==waddr)).
REQ-026 LU outside any memory stall: bk_pc=1, bk_ifid=1, flush_idex=1 in the same cycle, for exactly the cycles in which LU holds.
REQ-027 ex_jump_i=1 outside any memory stall: flush_ifid=1, flush_idex=1 in the same cycle; load-use outputs are suppressed that cycle.
REQ-028 Priority: memory stall/timeout > jump > load-use; during a memory stall, LU and ex_jump_i are ignored and are re-evaluated once the stall releases.
REQ-029 Register x0 never causes a hazard.
REQ-030 stall_cnt_o increments by 1 each cycle fc_bk_pc_o=1 and saturates at all ones.
REQ-031 All bk/flush outputs not driven high by REQ-021..027 SHALL be 0.

Reset
REQ-032 While rst_n=0: state RUN, wait_cnt=0, mem_err_o=0, stall_cnt_o=0, and all bk/flush outputs 0 regardless of inputs.
REQ-033 Reset asserted during MEM_WAIT aborts the wait with no mem_err_o pulse.

Verification
REQ-034 Load x5 in EX, ID reads rs1=5 with re=1 -> bk_pc=bk_ifid=flush_idex=1 for 1 cycle; stall_cnt_o 0->1.
REQ-035 exmem_mtype=1, mem_ready=0 for 3 cycles, then 1 -> bk_pc/ifid/idex/exmem and flush_memwb high 3 cycles, all low on the ready cycle, state back in RUN.
REQ-036 MEM_TIMEOUT=4, mem_ready held 0 -> 4 stall cycles, then a 5th cycle with flush_exmem=1 and bk_exmem=0, then a mem_err_o pulse 1 cycle wide.
REQ-037 ex_jump=1 together with LU conditions -> flush_ifid=flush_idex=1 and bk_pc=0; the same jump during a memory stall -> only the memory-stall outputs.
REQ-038 Load targeting x0 with ID rs1=0 -> no outputs asserted.
REQ-039 rst_n pulsed low mid-MEM_WAIT -> all outputs 0 immediately, stall_cnt_o=0, no mem_err_o pulse after release.

Source files
------------

// File: rtl/pipe_flow_ctrl_if.sv
// Flow-control bundle between the pipeline datapath and pipe_flow_ctrl.
// Signal suffixes are from the flow controller's point of view.
// master = pipeline side, slave = flow controller.
interface pipe_flow_ctrl_if #(
  parameter int CNT_W = 32
);
  // hazard sources from ID / EX / MEM
  logic [4:0]       id_rs1_raddr_i;
  logic [4:0]       id_rs2_raddr_i;
  logic             id_rs1_re_i;
  logic             id_rs2_re_i;
  logic [4:0]       ex_reg_waddr_i;
  logic             ex_reg_we_i;
  logic             ex_mtype_i;
  logic             ex_mem_rw_i;
  logic             ex_jump_i;
  logic             exmem_mtype_i;
  logic             mem_ready_i;
  // hold / flush controls
  logic             fc_bk_pc_o;
  logic             fc_bk_ifid_o;
  logic             fc_bk_idex_o;
  logic             fc_bk_exmem_o;
  logic             fc_flush_ifid_o;
  logic             fc_flush_idex_o;
  logic             fc_flush_exmem_o;
  logic             fc_flush_memwb_o;
  // status
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  // debug view of the memory-wait FSM
  logic             dbg_mem_wait_o;
  logic [7:0]       dbg_wait_cnt_o;

  modport master (
    output id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i, id_rs2_re_i,
           ex_reg_waddr_i, ex_reg_we_i, ex_mtype_i, ex_mem_rw_i, ex_jump_i,
           exmem_mtype_i, mem_ready_i,
    input  fc_bk_pc_o, fc_bk_ifid_o, fc_bk_idex_o, fc_bk_exmem_o,
           fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o,
           mem_err_o, stall_cnt_o, dbg_mem_wait_o, dbg_wait_cnt_o
  );

  modport slave (
    input  id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i, id_rs2_re_i,
           ex_reg_waddr_i, ex_reg_we_i, ex_mtype_i, ex_mem_rw_i, ex_jump_i,
           exmem_mtype_i, mem_ready_i,
    output fc_bk_pc_o, fc_bk_ifid_o, fc_bk_idex_o, fc_bk_exmem_o,
           fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o,
           mem_err_o, stall_cnt_o, dbg_mem_wait_o, dbg_wait_cnt_o
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: memory-wait stall with timeout abort, taken
// jump flush, load-use stall, and a saturating stall-cycle counter.
// Priority is memory stall/timeout > jump > load-use. Hold and flush are
// never raised together for the same pipeline register.
module pipe_flow_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_flow_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic mem_stall, load_use, timeout;
  logic bk_pc, bk_ifid, bk_idex, bk_exmem;
  logic fl_ifid, fl_idex, fl_exmem, fl_memwb;

  assign mem_stall = bus.exmem_mtype_i & ~bus.mem_ready_i;

  // x0 is hard-wired zero, so a load into it can never create a hazard
  assign load_use = bus.ex_mtype_i & ~bus.ex_mem_rw_i & bus.ex_reg_we_i &
                    (bus.ex_reg_waddr_i != 5'd0) &
                    ((bus.id_rs1_re_i & (bus.id_rs1_raddr_i == bus.ex_reg_waddr_i)) |
                     (bus.id_rs2_re_i & (bus.id_rs2_raddr_i == bus.ex_reg_waddr_i)));

  assign timeout = (state_q == ST_MEM_WAIT) && (wait_cnt_q >= TIMEOUT);

  // Next-state and hold/flush decode; memory stall masks jump and load-use
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    bk_pc      = 1'b0;
    bk_ifid    = 1'b0;
    bk_idex    = 1'b0;
    bk_exmem   = 1'b0;
    fl_ifid    = 1'b0;
    fl_idex    = 1'b0;
    fl_exmem   = 1'b0;
    fl_memwb   = 1'b0;
    if (mem_stall) begin
      bk_pc    = 1'b1;
      bk_ifid  = 1'b1;
      bk_idex  = 1'b1;
      fl_memwb = 1'b1;
      if (timeout) begin
        // abort: drop the stuck access instead of holding it
        fl_exmem   = 1'b1;
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
        mem_err_d  = 1'b1;
      end else begin
        bk_exmem   = 1'b1;
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = (state_q == ST_RUN) ? 8'd1 : wait_cnt_q + 8'd1;
      end
    end else begin
      state_d    = ST_RUN;
      wait_cnt_d = 8'd0;
      if (bus.ex_jump_i) begin
        fl_ifid = 1'b1;
        fl_idex = 1'b1;
      end else if (load_use) begin
        bk_pc   = 1'b1;
        bk_ifid = 1'b1;
        fl_idex = 1'b1;
      end
    end
  end

  // FSM, wait counter and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Saturating count of PC-hold cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bk_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Controls are forced low for the whole reset window
  assign bus.fc_bk_pc_o       = rst_n & bk_pc;
  assign bus.fc_bk_ifid_o     = rst_n & bk_ifid;
  assign bus.fc_bk_idex_o     = rst_n & bk_idex;
  assign bus.fc_bk_exmem_o    = rst_n & bk_exmem;
  assign bus.fc_flush_ifid_o  = rst_n & fl_ifid;
  assign bus.fc_flush_idex_o  = rst_n & fl_idex;
  assign bus.fc_flush_exmem_o = rst_n & fl_exmem;
  assign bus.fc_flush_memwb_o = rst_n & fl_memwb;
  assign bus.mem_err_o        = mem_err_q;
  assign bus.stall_cnt_o      = stall_cnt_q;
  assign bus.dbg_mem_wait_o   = (state_q == ST_MEM_WAIT);
  assign bus.dbg_wait_cnt_o   = wait_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: hand-computed vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_pipe_flow_ctrl;

  localparam int T  = 4;
  localparam int CW = 8;
  localparam int W  = 8 + 1 + CW;

  // output vector order: bk_pc bk_ifid bk_idex bk_exmem fl_ifid fl_idex fl_exmem fl_memwb
  localparam logic [7:0] O_NONE = 8'h00;
  localparam logic [7:0] O_LU   = 8'hC4;
  localparam logic [7:0] O_JMP  = 8'h0C;
  localparam logic [7:0] O_MEM  = 8'hF1;
  localparam logic [7:0] O_TMO  = 8'hE3;

  typedef struct packed {
    logic [4:0] rs1;
    logic       re1;
    logic [4:0] rs2;
    logic       re2;
    logic [4:0] waddr;
    logic       we;
    logic       mtype;
    logic       rw;
    logic       jump;
    logic       xm;
    logic       ready;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  pipe_flow_ctrl_if #(.CNT_W(CW)) bus();

  pipe_flow_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  in_t  cur_in;
  vec_t tab[14];
  // model: consecutive memory-stall cycles so far, pending error pulse, stall count
  int   m_run;
  bit   m_err;
  int   m_cnt;

  function automatic in_t mk(int rs1, int re1, int rs2, int re2, int wa, int we,
                             int mt, int rw, int jp, int xm, int rdy);
    in_t v;
    v.rs1 = 5'(rs1); v.re1 = 1'(re1); v.rs2 = 5'(rs2); v.re2 = 1'(re2);
    v.waddr = 5'(wa); v.we = 1'(we); v.mtype = 1'(mt); v.rw = 1'(rw);
    v.jump = 1'(jp); v.xm = 1'(xm); v.ready = 1'(rdy);
    return v;
  endfunction

  function automatic bit lu_f(in_t v);
    return v.mtype && !v.rw && v.we && (v.waddr != 0) &&
           ((v.re1 && v.rs1 == v.waddr) || (v.re2 && v.rs2 == v.waddr));
  endfunction

  function automatic logic [7:0] model_out(in_t v);
    if (v.xm && !v.ready) return (m_run == T) ? O_TMO : O_MEM;
    if (v.jump) return O_JMP;
    if (lu_f(v)) return O_LU;
    return O_NONE;
  endfunction

  function automatic logic [7:0] dut_outs();
    return {bus.fc_bk_pc_o, bus.fc_bk_ifid_o, bus.fc_bk_idex_o, bus.fc_bk_exmem_o,
            bus.fc_flush_ifid_o, bus.fc_flush_idex_o, bus.fc_flush_exmem_o,
            bus.fc_flush_memwb_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input in_t v);
    cur_in = v;
    bus.id_rs1_raddr_i = v.rs1;  bus.id_rs1_re_i = v.re1;
    bus.id_rs2_raddr_i = v.rs2;  bus.id_rs2_re_i = v.re2;
    bus.ex_reg_waddr_i = v.waddr; bus.ex_reg_we_i = v.we;
    bus.ex_mtype_i = v.mtype;    bus.ex_mem_rw_i = v.rw;
    bus.ex_jump_i = v.jump;      bus.exmem_mtype_i = v.xm;
    bus.mem_ready_i = v.ready;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock with current inputs: model check at negedge, optional constant check,
  // then advance the model at the rising edge.
  task automatic step(input string nm, input bit use_c, input logic [7:0] c);
    logic [7:0]   e;
    logic [W-1:0] got, ex;
    @(negedge clk);
    e = model_out(cur_in);
    exp_q.push_back({e, m_err, CW'(m_cnt)});
    got = {dut_outs(), bus.mem_err_o, bus.stall_cnt_o};
    ex  = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin
      n_bad++;
      $display("FAIL %s: got outs=%0h err=%0b cnt=%0d expected outs=%0h err=%0b cnt=%0d",
               nm, got[W-1:W-8], got[CW], got[CW-1:0], ex[W-1:W-8], ex[CW], ex[CW-1:0]);
    end
    if (use_c) chk({nm, "_const"}, 32'(dut_outs()), 32'(c));
    @(posedge clk);
    if (e[7]) m_cnt = (m_cnt >= (1 << CW) - 1) ? m_cnt : m_cnt + 1;
    m_err = (e == O_TMO);
    if (cur_in.xm && !cur_in.ready) m_run = (m_run == T) ? 0 : m_run + 1;
    else m_run = 0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(5, 1, 0, 0, 5, 1, 1, 0, 1, 1, 0));
    #3;
    chk("reset_outs", {23'd0, dut_outs(), bus.mem_err_o}, 32'd0);
    chk("reset_cnt", 32'(bus.stall_cnt_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive('0);
    rst_n = 1'b1;
    m_run = 0; m_err = 1'b0; m_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive('0);
    m_run = 0; m_err = 1'b0; m_cnt = 0;

    tab[0]  = '{mk(0,0,0,0,0,0,0,0,0,0,1), O_NONE};
    tab[1]  = '{mk(5,1,0,0,5,1,1,0,0,0,1), O_LU};
    tab[2]  = '{mk(5,0,0,0,5,1,1,0,0,0,1), O_NONE};
    tab[3]  = '{mk(0,0,5,1,5,1,1,0,0,0,1), O_LU};
    tab[4]  = '{mk(5,1,0,0,5,1,1,1,0,0,1), O_NONE};
    tab[5]  = '{mk(0,1,0,0,0,1,1,0,0,0,1), O_NONE};
    tab[6]  = '{mk(0,0,0,0,0,0,0,0,1,0,1), O_JMP};
    tab[7]  = '{mk(5,1,0,0,5,1,1,0,1,0,1), O_JMP};
    tab[8]  = '{mk(5,1,0,0,5,1,0,0,0,0,1), O_NONE};
    tab[9]  = '{mk(5,1,0,0,5,0,1,0,0,0,1), O_NONE};
    tab[10] = '{mk(5,1,0,0,5,1,1,0,0,1,1), O_LU};
    tab[11] = '{mk(0,0,0,0,0,0,0,0,1,0,0), O_JMP};
    tab[12] = '{mk(7,1,7,1,6,1,1,0,0,0,1), O_NONE};
    tab[13] = '{mk(3,0,9,1,9,1,1,0,0,0,1), O_LU};

    do_reset();

    // single-cycle vector table
    for (int i = 0; i < 14; i++) begin
      drive(tab[i].in);
      step($sformatf("tab%0d", i), 1'b1, tab[i].exp);
    end

    // load-use for one cycle bumps the counter from 0 to 1
    do_reset();
    drive(mk(5,1,0,0,5,1,1,0,0,0,1));
    step("lu_one", 1'b1, O_LU);
    chk("lu_cnt", 32'(bus.stall_cnt_o), 32'd1);
    drive('0);
    step("lu_after", 1'b1, O_NONE);

    // memory wait of 3 cycles, then ready
    do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,1,0));
    for (int i = 0; i < 3; i++) step("mw_stall", 1'b1, O_MEM);
    chk("mw_state", 32'(bus.dbg_mem_wait_o), 32'd1);
    drive(mk(0,0,0,0,0,0,0,0,0,1,1));
    step("mw_ready", 1'b1, O_NONE);
    chk("mw_back_run", 32'(bus.dbg_mem_wait_o), 32'd0);
    chk("mw_cnt", 32'(bus.stall_cnt_o), 32'd3);

    // memory timeout: 4 stalls, abort cycle, then a one-cycle error pulse
    do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,1,0));
    for (int i = 0; i < T; i++) step("to_stall", 1'b1, O_MEM);
    step("to_abort", 1'b1, O_TMO);
    drive('0);
    chk("to_err_hi", 32'(bus.mem_err_o), 32'd1);
    step("to_err_cyc", 1'b1, O_NONE);
    chk("to_err_lo", 32'(bus.mem_err_o), 32'd0);
    step("to_idle", 1'b1, O_NONE);

    // jump with load-use, then the same jump during a memory stall
    do_reset();
    drive(mk(5,1,0,0,5,1,1,0,1,0,1));
    step("jmp_lu", 1'b1, O_JMP);
    drive(mk(5,1,0,0,5,1,1,0,1,1,0));
    step("jmp_mem", 1'b1, O_MEM);
    step("jmp_mem2", 1'b1, O_MEM);
    drive(mk(5,1,0,0,5,1,1,0,1,1,1));
    step("jmp_release", 1'b1, O_JMP);
    drive(mk(5,1,0,0,5,1,1,0,0,1,1));
    step("lu_release", 1'b1, O_LU);

    // reset pulse in the middle of a memory wait
    do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,1,0));
    step("rw_stall", 1'b1, O_MEM);
    step("rw_stall", 1'b1, O_MEM);
    rst_n = 1'b0;
    #1;
    chk("rw_outs", 32'(dut_outs()), 32'd0);
    chk("rw_cnt", 32'(bus.stall_cnt_o), 32'd0);
    chk("rw_state", 32'(bus.dbg_mem_wait_o), 32'd0);
    @(posedge clk);
    #1;
    drive('0);
    rst_n = 1'b1;
    m_run = 0; m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step("rw_post", 1'b1, O_NONE);
      chk("rw_no_err", 32'(bus.mem_err_o), 32'd0);
    end

    // counter saturation
    do_reset();
    drive(mk(5,1,0,0,5,1,1,0,0,0,1));
    for (int i = 0; i < 260; i++) step("sat_lu", 1'b0, O_NONE);
    chk("sat_cnt", 32'(bus.stall_cnt_o), 32'hFF);

    // randomized traffic against the model
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 5 : 9);
      for (int i = 0; i < 200; i++) begin
        in_t v;
        v.rs1   = 5'($urandom_range(0, 3));
        v.re1   = 1'($urandom_range(0, 1));
        v.rs2   = 5'($urandom_range(0, 3));
        v.re2   = 1'($urandom_range(0, 1));
        v.waddr = 5'($urandom_range(0, 3));
        v.we    = 1'($urandom_range(0, 1));
        v.mtype = 1'($urandom_range(0, 1));
        v.rw    = 1'($urandom_range(0, 1));
        v.jump  = ($urandom_range(0, 3) == 0);
        v.xm    = ($urandom_range(0, 9) < 7);
        v.ready = ($urandom_range(0, 9) < rdy_pct);
        drive(v);
        step("rand", 1'b0, O_NONE);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
